// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encodings, default width and counter sizing shared by the serial adder.
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/fa_cell.sv
// fa_cell: gate-level 1-bit full adder.
module fa_cell (
   input  logic x1,
   input  logic x2,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = x1 ^ x2;
   assign s    = p ^ cin;
   assign cout = (x1 & x2) | (cin & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell reused LSB-first over WIDTH cycles.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, busy_q, done_q, cout_q, fa_s, fa_c;

   fa_cell u_fa (
      .x1  (a_q[0]),
      .x2  (b_q[0]),
      .cin (c_q),
      .s   (fa_s),
      .cout(fa_c)
   );

   // result fills from the MSB so after WIDTH shifts bit 0 holds the first cell sum
   assign res_d = {fa_s, res_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               a_q     <= a;
               b_q     <= b;
               c_q     <= cin;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= ADD;
            end
            ADD: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= fa_c;
               res_q <= res_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum_q   <= res_d;
                  cout_q  <= fa_c;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int           n_cmp = 0;
   int           n_fail = 0;
   logic [W:0]   exp_q[$];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc, input bit push);
      a = ta;
      b = tb2;
      cin = tc;
      start = 1'b1;
      if (push) exp_q.push_back({1'b0, ta} + {1'b0, tb2} + (W+1)'(tc));
   endtask

   task automatic wait_done(output int n, output int bn);
      n = 0;
      bn = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (busy) bn++;
      end while (done !== 1'b1 && n < 4*W);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, cout, sum} !== '0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_basic;
      int n, bn;
      logic [W:0] e;
      @(negedge clk);
      issue(8'h01, 8'h01, 1'b0, 1);
      wait_done(n, bn);
      e = exp_q.pop_front();
      n_cmp++;
      if (n !== W + 1) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d cycles, required %0d", n, W + 1);
      end
      n_cmp++;
      if ({cout, sum} !== e) begin
         n_fail++;
         $display("FAIL basic_result: got %h, required %h", {cout, sum}, e);
      end
      @(negedge clk);
      if (busy) bn++;
      n_cmp++;
      if (bn !== W + 1) begin
         n_fail++;
         $display("FAIL basic_busy: busy for %0d cycles, required %0d", bn, W + 1);
      end
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pulse: done=%b a cycle after done, required 0", done);
      end
   endtask

   task automatic test_add(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
      int n, bn;
      logic [W:0] e;
      @(negedge clk);
      issue(ta, tb2, tc, 1);
      wait_done(n, bn);
      e = exp_q.pop_front();
      n_cmp++;
      if (n !== W + 1 || {cout, sum} !== e) begin
         n_fail++;
         $display("FAIL add %h+%h+%b: got %h after %0d cycles, required %h after %0d", ta, tb2, tc, {cout, sum}, n, e, W + 1);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 256; i++)
         test_add(W'($urandom), W'($urandom), 1'($urandom));
   endtask

   task automatic test_start_while_busy;
      int dn, bn;
      logic [W:0] e;
      dn = 0;
      bn = 0;
      @(negedge clk);
      issue(8'h10, 8'h20, 1'b0, 1);
      for (int i = 1; i <= W + 1; i++) begin
         @(negedge clk);
         if (done) dn++;
         start = (i == 3 || i == 9);
         a = 8'hAA;
         b = 8'h55;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({cout, sum} !== e) begin
         n_fail++;
         $display("FAIL busy_start_result: got %h, required %h", {cout, sum}, e);
      end
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dn++;
         if (busy) bn++;
      end
      n_cmp++;
      if (dn !== 1 || bn !== 0) begin
         n_fail++;
         $display("FAIL busy_start_ignored: %0d done pulses, %0d busy after, required 1 and 0", dn, bn);
      end
   endtask

   task automatic test_back_to_back;
      int n, bn, n2;
      bit hold_bad;
      logic [W:0] e1, e2;
      hold_bad = 0;
      @(negedge clk);
      issue(8'h3C, 8'h4B, 1'b1, 1);
      wait_done(n, bn);
      e1 = exp_q.pop_front();
      n_cmp++;
      if ({cout, sum} !== e1) begin
         n_fail++;
         $display("FAIL b2b_first: got %h, required %h", {cout, sum}, e1);
      end
      @(negedge clk);
      issue(8'hC8, 8'h64, 1'b0, 1);
      n2 = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n2++;
         if (!done && {cout, sum} !== e1) hold_bad = 1;
      end while (done !== 1'b1 && n2 < 4*W);
      e2 = exp_q.pop_front();
      n_cmp++;
      if (n2 + 1 !== W + 2) begin
         n_fail++;
         $display("FAIL b2b_period: done-to-done %0d cycles, required %0d", n2 + 1, W + 2);
      end
      n_cmp++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL b2b_hold: sum/cout changed during next op, required %h held", e1);
      end
      n_cmp++;
      if ({cout, sum} !== e2) begin
         n_fail++;
         $display("FAIL b2b_second: got %h, required %h", {cout, sum}, e2);
      end
   endtask

   task automatic test_reset_mid;
      int dn;
      bit nz;
      dn = 0;
      nz = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(8'h0F, 8'h01, 1'b0, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_busy: busy=%b, required 0", busy);
      end
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (done) dn++;
         if ({cout, sum} !== '0) nz = 1;
      end
      n_cmp++;
      if (dn !== 0 || nz) begin
         n_fail++;
         $display("FAIL mid_reset_abort: %0d done pulses, sum/cout=%h, required 0 and 0", dn, {cout, sum});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_add(8'hFF, 8'h01, 1'b0);
      test_add(8'hFF, 8'hFF, 1'b1);
      test_add(8'h00, 8'h00, 1'b1);
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, first operand; captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, WIDTH, second operand; captured on the accepted start edge.
REQ-007 The block SHALL have port cin, input, 1, carry-in; captured on the accepted start edge.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress (states ADD and DONE).
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH, result register.
REQ-011 The block SHALL have port cout, output, 1, final carry-out register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-013 In IDLE with start=1, the next edge SHALL load a and b into operand shift registers, load cin into the carry flop, clear the bit counter and enter ADD.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE with all registers held.
REQ-015 Each ADD cycle SHALL apply operand LSBs and the carry flop to one fa_cell instance.
REQ-016 Each ADD cycle SHALL shift the cell sum bit into the MSB of an internal result shift register, shift both operand registers right by one, load the cell carry into the carry flop, and increment the counter.
REQ-017 ADD SHALL last exactly WIDTH cycles; on the edge where counter == WIDTH-1, the FSM SHALL enter DONE.
REQ-018 On the edge entering DONE, sum SHALL be loaded with the completed result shift register and cout with the final cell carry.
REQ-019 sum and cout SHALL change only on entry to DONE or on reset, and SHALL hold their values otherwise, including throughout the next operation.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL return unconditionally to IDLE.
REQ-021 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-022 start SHALL be ignored in ADD and DONE; no queuing, and operand changes while busy SHALL have no effect.
REQ-023 A start presented in the first IDLE cycle after done SHALL be accepted, so back-to-back operations occupy WIDTH+2 cycles each.
REQ-024 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout equal to bit WIDTH of the full sum.

Reset
REQ-025 When rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, cout, the counter, the carry flop and all shift registers SHALL become 0.
REQ-026 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and SHALL NOT update sum or cout.

Structure
REQ-027 State encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package/include serial_adder_pkg.
REQ-028 The counter width SHALL be $clog2(WIDTH) bits, defined in the same package.
REQ-029 The block SHALL contain one sub-module, fa_cell: a combinational gate-level 1-bit full adder (inputs x1, x2, cin; outputs s, cout).
REQ-030 fa_cell SHALL be independently testable.

Verification (WIDTH=8)
REQ-031 Reset: rst=1 for 2 cycles -> busy=0, done=0, sum=8'h00, cout=0.
REQ-032 Basic add: a=8'h01, b=8'h01, cin=0 -> done exactly 9 cycles after the start edge, sum=8'h02, cout=0, busy high for 9 cycles.
REQ-033 Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
REQ-034 All ones: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; the bench SHALL also compare 256 random a/b/cin triples against a behavioural model.
REQ-035 Start while busy: start pulsed at cycles 3 and 9 of an operation with a=8'h10, b=8'h20 -> single done, sum=8'h30; a start on the cycle after done is accepted.
REQ-036 Reset mid-operation: rst at ADD cycle 4 of a=8'h0F, b=8'h01 -> next cycle busy=0, no done pulse, sum/cout remain 0.
